// File: rtl/iir_filter_pkg.sv
// Shared definitions for the two-channel power-of-two IIR filter cascade.
//   state_bits() : width of one state entry (samples scaled by 2^K)
//   stage_idx_t  : sequencer index {channel, stage}
//   CH_A / CH_B  : channel encodings used in the index
package iir_filter_pkg;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    // Two channels times eight stages.
    localparam int unsigned NUM_ENTRIES = 16;

    typedef struct packed {
        logic       ch;
        logic [2:0] st;
    } stage_idx_t;

    // Each entry holds y * 2^K, so it needs K extra fraction bits.
    function automatic int unsigned state_bits(input int unsigned data_bits,
                                               input int unsigned k_shift);
        return data_bits + k_shift;
    endfunction

endpackage

// File: rtl/iir_stage_update.sv
// One first-order low-pass step: new = state - (state >> K) + x, out = new >> K.
// Purely combinational; the caller owns the state storage.
//   cur_state : stored y * 2^K for the stage being processed
//   x         : stage input sample
//   new_state : value to write back into the same entry
//   y         : stage output, new_state >> K (floor)
module iir_stage_update
    import iir_filter_pkg::*;
#(
    parameter int unsigned DATA_BITS      = 32,
    parameter int unsigned FILTER_K_SHIFT = 6,
    localparam int unsigned S             = state_bits(DATA_BITS, FILTER_K_SHIFT)
) (
    input  logic [S-1:0]         cur_state,
    input  logic [DATA_BITS-1:0] x,
    output logic [S-1:0]         new_state,
    output logic [DATA_BITS-1:0] y
);

    logic [S:0] sum_wide;
    logic       unused_sum_msb;

    // state - (state >> K) <= 2^S - 2^D, so adding any D-bit x never reaches 2^S;
    // the extra bit only guards the intermediate sum.
    always_comb begin
        sum_wide = {1'b0, cur_state} - ({1'b0, cur_state} >> FILTER_K_SHIFT)
                 + {{(S + 1 - DATA_BITS){1'b0}}, x};
    end

    assign new_state      = sum_wide[S-1:0];
    assign y              = sum_wide[S-1:FILTER_K_SHIFT];
    assign unused_sum_msb = sum_wide[S];

endmodule

// File: rtl/iir_filter_pow2_k.sv
// Two-channel, time-multiplexed cascade of up to eight first-order low-pass stages
// with coefficient 2^-FILTER_K_SHIFT. One (channel, stage) pair is processed per cycle
// in the order A0..A(M), B0..B(M); M is latched from MAX_STAGE at each A0.
//   CLK         : clock, rising edge
//   RESET       : synchronous, active-high; clears state, forward reg and outputs
//   IN_VALUE_A  : channel A raw sample (sampled in the A0 cycle)
//   IN_VALUE_B  : channel B raw sample (sampled in the B0 cycle)
//   MAX_STAGE   : index of the last active stage (depth = MAX_STAGE + 1)
//   OUT_VALUE_A : filtered channel A, updated when A(M) is processed
//   OUT_VALUE_B : filtered channel B, updated when B(M) is processed
module iir_filter_pow2_k
    import iir_filter_pkg::*;
#(
    parameter int unsigned FILTER_K_SHIFT = 6,
    parameter int unsigned DATA_BITS      = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [DATA_BITS-1:0] IN_VALUE_A,
    input  logic [DATA_BITS-1:0] IN_VALUE_B,
    input  logic [2:0]           MAX_STAGE,
    output logic [DATA_BITS-1:0] OUT_VALUE_A,
    output logic [DATA_BITS-1:0] OUT_VALUE_B
);

    localparam int unsigned S = state_bits(DATA_BITS, FILTER_K_SHIFT);

    stage_idx_t           idx_q, idx_d;
    logic [2:0]           m_q, m_eff;
    logic [S-1:0]         state_q [NUM_ENTRIES];
    logic [S-1:0]         cur_state, new_state;
    logic [DATA_BITS-1:0] fwd_q, x, y;
    logic [DATA_BITS-1:0] out_a_q, out_b_q;
    logic                 at_a0, last_stage;

    always_comb begin
        at_a0      = (idx_q.ch == CH_A) && (idx_q.st == 3'd0);
        // The pass that starts now uses the live MAX_STAGE; later cycles use the latch.
        m_eff      = at_a0 ? MAX_STAGE : m_q;
        last_stage = (idx_q.st == m_eff);
        cur_state  = state_q[{idx_q.ch, idx_q.st}];

        if (idx_q.st == 3'd0) begin
            x = (idx_q.ch == CH_A) ? IN_VALUE_A : IN_VALUE_B;
        end else begin
            x = fwd_q;
        end

        idx_d = idx_q;
        if (last_stage) begin
            idx_d.ch = ~idx_q.ch;
            idx_d.st = 3'd0;
        end else begin
            idx_d.st = idx_q.st + 3'd1;
        end
    end

    iir_stage_update #(
        .DATA_BITS      (DATA_BITS),
        .FILTER_K_SHIFT (FILTER_K_SHIFT)
    ) u_stage (
        .cur_state (cur_state),
        .x         (x),
        .new_state (new_state),
        .y         (y)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= '0;
            end
            fwd_q   <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
            idx_q   <= '0;
            m_q     <= '0;
        end else begin
            state_q[{idx_q.ch, idx_q.st}] <= new_state;
            fwd_q <= y;
            idx_q <= idx_d;
            if (at_a0) begin
                m_q <= MAX_STAGE;
            end
            if (last_stage) begin
                if (idx_q.ch == CH_A) begin
                    out_a_q <= y;
                end else begin
                    out_b_q <= y;
                end
            end
        end
    end

    assign OUT_VALUE_A = out_a_q;
    assign OUT_VALUE_B = out_b_q;

endmodule

// File: tb/tb_iir_filter_pow2_k.sv
// Self-checking bench for iir_filter_pow2_k (K = 6, 32-bit samples).
// A pass-level reference model predicts each output update and the cycle in which
// it becomes visible; a monitor compares both outputs against it every cycle.
module tb_iir_filter_pow2_k;

    localparam int unsigned K = 6;

    logic        CLK         = 1'b0;
    logic        RESET       = 1'b1;
    logic [31:0] IN_VALUE_A  = '0;
    logic [31:0] IN_VALUE_B  = '0;
    logic [2:0]  MAX_STAGE   = '0;
    logic [31:0] OUT_VALUE_A;
    logic [31:0] OUT_VALUE_B;

    always #5 CLK = ~CLK;

    iir_filter_pow2_k #(
        .FILTER_K_SHIFT (K),
        .DATA_BITS      (32)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IN_VALUE_A  (IN_VALUE_A),
        .IN_VALUE_B  (IN_VALUE_B),
        .MAX_STAGE   (MAX_STAGE),
        .OUT_VALUE_A (OUT_VALUE_A),
        .OUT_VALUE_B (OUT_VALUE_B)
    );

    typedef struct {
        int unsigned cyc;
        logic        ch;
        logic [31:0] val;
    } ev_t;

    typedef struct {
        logic [31:0] in_a;
        logic [31:0] in_b;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    ev_t         sb_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    logic [31:0] exp_a   = '0;
    logic [31:0] exp_b   = '0;
    logic [31:0] prev_a  = '0;
    logic [31:0] prev_b  = '0;
    int unsigned chg_a   = 0;
    int unsigned chg_b   = 0;
    logic [63:0] mst [2][8];
    logic [31:0] last_ya, last_yb;

    // Index of the cycle currently in progress; cycle 0 is the first one after reset.
    always @(posedge CLK) cyc <= RESET ? 0 : cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: one full pass of a channel, stages 0..m, unbounded 64-bit arithmetic.
    task automatic model_pass(input int ch, input logic [31:0] x, input int unsigned m,
                              output logic [31:0] y);
        logic [63:0] xin, nxt;
        xin = {32'h0, x};
        for (int s = 0; s <= int'(m); s++) begin
            nxt        = mst[ch][s] - (mst[ch][s] >> K) + xin;
            mst[ch][s] = nxt;
            xin        = nxt >> K;
        end
        y = xin[31:0];
    endtask

    // Monitor: sample 1 time unit after each edge.
    always @(posedge CLK) begin
        #1;
        if (!RESET) begin
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                if (sb_q[0].ch == 1'b0) exp_a = sb_q[0].val;
                else                    exp_b = sb_q[0].val;
                void'(sb_q.pop_front());
            end
            check("sb_out_a", OUT_VALUE_A, exp_a);
            check("sb_out_b", OUT_VALUE_B, exp_b);
        end
        if (OUT_VALUE_A !== prev_a) chg_a = cyc;
        if (OUT_VALUE_B !== prev_b) chg_b = cyc;
        prev_a = OUT_VALUE_A;
        prev_b = OUT_VALUE_B;
    end

    task automatic do_reset();
        RESET      = 1'b1;
        IN_VALUE_A = 32'hDEADBEEF;
        IN_VALUE_B = 32'h13579BDF;
        MAX_STAGE  = 3'd5;
        sb_q.delete();
        exp_a = '0;
        exp_b = '0;
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 8; s++) mst[c][s] = '0;
        end
        repeat (15) @(negedge CLK);
        check("reset_out_a", OUT_VALUE_A, 32'h0);
        check("reset_out_b", OUT_VALUE_B, 32'h0);
        RESET = 1'b0;
    endtask

    // Called at the negedge of an A0 cycle; drives one full pass and queues the
    // expected output updates. MAX_STAGE may be changed mid-pass at offset mid_at.
    task automatic run_pass(input logic [31:0] a, input logic [31:0] b, input int unsigned m,
                            input int unsigned mid_at, input logic [2:0] mid_m);
        int unsigned t;
        ev_t         ev;
        IN_VALUE_A = a;
        IN_VALUE_B = b;
        MAX_STAGE  = 3'(m);
        t = cyc;
        model_pass(0, a, m, last_ya);
        ev.cyc = t + m + 1;
        ev.ch  = 1'b0;
        ev.val = last_ya;
        sb_q.push_back(ev);
        model_pass(1, b, m, last_yb);
        ev.cyc = t + 2 * m + 2;
        ev.ch  = 1'b1;
        ev.val = last_yb;
        sb_q.push_back(ev);
        for (int unsigned i = 0; i < 2 * (m + 1); i++) begin
            if (i == mid_at) MAX_STAGE = mid_m;
            @(negedge CLK);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[4];
        int unsigned t0, prev_chg, n;
        logic [31:0] prev_out;

        // Single stage (M = 0), hand-computed pass-by-pass values.
        vecs[0] = '{32'h12000000, 32'h00001000, 32'h00480000, 32'h00000040};
        vecs[1] = '{32'h12000000, 32'h00001000, 32'h008EE000, 32'h0000007F};
        vecs[2] = '{32'h12000000, 32'h00001000, 32'h00D4A480, 32'h000000BD};
        vecs[3] = '{32'h00000000, 32'h00001000, 32'h00D151EE, 32'h000000FA};

        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_pass(vecs[i].in_a, vecs[i].in_b, 0, 99, 3'd0);
            check($sformatf("vec%0d_a", i), OUT_VALUE_A, vecs[i].exp_a);
            check($sformatf("vec%0d_b", i), OUT_VALUE_B, vecs[i].exp_b);
        end

        // Convergence up then down, four stages.
        do_reset();
        prev_out = '0;
        n = 0;
        do begin
            run_pass(32'h45000000, 32'h0, 3, 99, 3'd0);
            check("conv_up_mono", 32'(OUT_VALUE_A >= prev_out), 32'd1);
            prev_out = OUT_VALUE_A;
            n++;
        end while (last_ya != 32'h45000000 && n < 3000);
        check("conv_up_final", OUT_VALUE_A, 32'h45000000);
        n = 0;
        do begin
            run_pass(32'h15000000, 32'h0, 3, 99, 3'd0);
            check("conv_dn_mono", 32'(OUT_VALUE_A <= prev_out), 32'd1);
            prev_out = OUT_VALUE_A;
            n++;
        end while (last_ya != 32'h15000000 && n < 3000);
        check("conv_dn_final", OUT_VALUE_A, 32'h15000000);

        // Full scale on B with eight stages, then a single stage to finish settling.
        do_reset();
        prev_out = '0;
        for (int i = 0; i < 300; i++) begin
            run_pass(32'h0, 32'hFFFFFFFF, 7, 99, 3'd0);
            check("fs_mono", 32'(OUT_VALUE_B >= prev_out), 32'd1);
            check("fs_iso_a", OUT_VALUE_A, 32'h0);
            prev_out = OUT_VALUE_B;
        end
        n = 0;
        do begin
            run_pass(32'h0, 32'hFFFFFFFF, 0, 99, 3'd0);
            check("fs_mono", 32'(OUT_VALUE_B >= prev_out), 32'd1);
            prev_out = OUT_VALUE_B;
            n++;
        end while (last_yb != 32'hFFFFFFFF && n < 3000);
        check("fs_final_b", OUT_VALUE_B, 32'hFFFFFFFF);
        check("fs_iso_a", OUT_VALUE_A, 32'h0);

        // Latency and cadence with M = 3.
        do_reset();
        repeat (2) run_pass(32'h0, 32'h0, 3, 99, 3'd0);
        t0 = cyc;
        run_pass(32'h40000000, 32'h80000000, 3, 99, 3'd0);
        check("latency_a", chg_a, t0 + 4);
        check("latency_b", chg_b, t0 + 8);
        for (int i = 0; i < 3; i++) begin
            prev_chg = chg_a;
            run_pass(32'h40000000, 32'h80000000, 3, 99, 3'd0);
            check("cadence_a", chg_a - prev_chg, 32'd8);
        end

        // Depth 3 -> 1 requested mid-pass: current pass still ends at stage 3.
        t0 = cyc;
        run_pass(32'h40000000, 32'h80000000, 3, 2, 3'd1);
        check("depth_old_a", chg_a, t0 + 4);
        check("depth_old_b", chg_b, t0 + 8);
        t0 = cyc;
        run_pass(32'h40000000, 32'h80000000, 1, 99, 3'd0);
        check("depth_new_a", chg_a, t0 + 2);
        check("depth_new_b", chg_b, t0 + 4);
        for (int i = 0; i < 3; i++) begin
            prev_chg = chg_a;
            run_pass(32'h40000000, 32'h80000000, 1, 99, 3'd0);
            check("depth_period_a", chg_a - prev_chg, 32'd4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
